// File: rtl/secam_decoder_pkg.sv
// Shared types and helpers for the SECAM chroma FM demodulator: FSM state
// encoding, internal datapath widths and the 8-bit saturation helper.
package secam_decoder_pkg;

  localparam int CNT_W = 12;
  localparam int DEV_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEEK    = 2'd1,
    MEASURE = 2'd2
  } state_e;

  localparam logic signed [DEV_W-1:0] SAT_MAX = 16'sd127;
  localparam logic signed [DEV_W-1:0] SAT_MIN = -16'sd128;

  // Clamp a 16-bit signed deviation into the 8-bit colour-difference range.
  function automatic logic signed [7:0] sat8(input logic signed [DEV_W-1:0] x);
    logic signed [7:0] r;
    if (x > SAT_MAX) begin
      r = 8'sd127;
    end else if (x < SAT_MIN) begin
      r = -8'sd127 - 8'sd1;
    end else begin
      r = x[7:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/secam_decoder_zero_crossing_detector.sv
// Rising zero-crossing detector with hysteresis: arms on a sample at or below
// -HYST, fires a registered one-cycle pulse on the first non-negative sample.
module zero_crossing_detector #(
  parameter int HYST = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic signed [7:0] chroma,
  output logic              crossing
);

  localparam logic signed [8:0] ARM_LEVEL = 9'(-HYST);

  logic              armed_q;
  logic              armed_d;
  logic              cross_q;
  logic              cross_d;
  logic signed [8:0] chroma_x;

  assign chroma_x = {chroma[7], chroma};

  // A crossing consumes the arming, so a noisy sample near zero cannot
  // retrigger until the waveform has swung back below -HYST.
  always_comb begin
    armed_d = armed_q;
    cross_d = 1'b0;
    if (armed_q && !chroma[7]) begin
      cross_d = 1'b1;
      armed_d = 1'b0;
    end else if (chroma_x <= ARM_LEVEL) begin
      armed_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
      cross_q <= 1'b0;
    end else begin
      armed_q <= armed_d;
      cross_q <= cross_d;
    end
  end

  assign crossing = cross_q;

endmodule

// File: rtl/secam_decoder.sv
// SECAM chroma FM demodulator: counts clocks over CYCLES carrier periods and
// maps the deviation from the Db/Dr nominal count onto signed U/V samples.
// Optional de-emphasis filter: define SECAM_DECODER_DEEMPHASIS_EN.
module secam_decoder
  import secam_decoder_pkg::*;
#(
  parameter int CYCLES       = 8,
  parameter int NOMINAL_DB   = 90,
  parameter int NOMINAL_DR   = 87,
  parameter int HYST         = 8,
  parameter int GAIN_SHIFT   = 2,
  parameter int DEEMPH_SHIFT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic signed [7:0] chroma,
  input  logic              even_line,
  input  logic              enabled,
  output logic signed [7:0] yuv_u,
  output logic signed [7:0] yuv_v,
  output logic              valid,
  output logic              no_carrier
);

  localparam int TIMEOUT = 2 * ((NOMINAL_DB > NOMINAL_DR) ? NOMINAL_DB : NOMINAL_DR);
  localparam logic [CNT_W-1:0]        TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic signed [DEV_W-1:0] NOM_DB_S    = DEV_W'(NOMINAL_DB);
  localparam logic signed [DEV_W-1:0] NOM_DR_S    = DEV_W'(NOMINAL_DR);
  localparam logic [4:0]              LAST_CROSS  = 5'(CYCLES - 1);

`ifdef SECAM_DECODER_DEEMPHASIS_EN
  localparam bit DEEMPH = 1'b1;
`else
  localparam bit DEEMPH = 1'b0;
`endif

  logic signed [7:0]       chroma_q;
  logic                    crossing;

  state_e                  state_q;
  logic [CNT_W-1:0]        count_q;
  logic [4:0]              ncross_q;
  logic                    line_q;
  logic signed [7:0]       yuv_u_q;
  logic signed [7:0]       yuv_v_q;
  logic                    valid_q;
  logic                    no_carrier_q;

  logic [CNT_W-1:0]        cnt_now;
  logic                    timeout;
  logic                    last_cross;
  logic signed [DEV_W-1:0] cnt_s;
  logic signed [DEV_W-1:0] dev;
  logic signed [DEV_W-1:0] gained;
  logic signed [7:0]       res;
  logic signed [DEV_W-1:0] diff_u;
  logic signed [DEV_W-1:0] diff_v;
  logic signed [DEV_W-1:0] sum_u;
  logic signed [DEV_W-1:0] sum_v;
  logic signed [7:0]       yuv_u_d;
  logic signed [7:0]       yuv_v_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chroma_q <= '0;
    end else begin
      chroma_q <= chroma;
    end
  end

  zero_crossing_detector #(
    .HYST(HYST)
  ) u_zcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .chroma  (chroma_q),
    .crossing(crossing)
  );

  // count_q holds clocks elapsed minus one, so cnt_now is the window length
  // as seen on the cycle a crossing arrives.
  always_comb begin
    cnt_now    = count_q + 12'd1;
    timeout    = cnt_now > TIMEOUT_CNT;
    last_cross = (ncross_q == LAST_CROSS);
    cnt_s      = $signed({{(DEV_W - CNT_W){1'b0}}, cnt_now});
    if (line_q) begin
      dev = NOM_DB_S - cnt_s;
    end else begin
      dev = cnt_s - NOM_DR_S;
    end
    gained = dev <<< GAIN_SHIFT;
    res    = sat8(gained);
  end

  // The filter state is the output register itself, so latency is unchanged.
  always_comb begin
    diff_u = DEV_W'(res) - DEV_W'(yuv_u_q);
    diff_v = DEV_W'(res) - DEV_W'(yuv_v_q);
    sum_u  = DEV_W'(yuv_u_q) + (diff_u >>> DEEMPH_SHIFT);
    sum_v  = DEV_W'(yuv_v_q) + (diff_v >>> DEEMPH_SHIFT);
    if (DEEMPH) begin
      yuv_u_d = sat8(sum_u);
      yuv_v_d = sat8(sum_v);
    end else begin
      yuv_u_d = res;
      yuv_v_d = res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      ncross_q     <= '0;
      line_q       <= 1'b0;
      yuv_u_q      <= '0;
      yuv_v_q      <= '0;
      valid_q      <= 1'b0;
      no_carrier_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      line_q  <= even_line;
      if (!enabled) begin
        state_q  <= IDLE;
        count_q  <= '0;
        ncross_q <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            state_q  <= SEEK;
            count_q  <= '0;
            ncross_q <= '0;
          end
          SEEK: begin
            if (crossing) begin
              state_q  <= MEASURE;
              count_q  <= '0;
              ncross_q <= '0;
            end
          end
          MEASURE: begin
            // Priority: line change, then timeout, then window close.
            if (even_line != line_q) begin
              state_q <= SEEK;
            end else if (timeout) begin
              state_q      <= SEEK;
              no_carrier_q <= 1'b1;
            end else if (crossing && last_cross) begin
              count_q      <= '0;
              ncross_q     <= '0;
              valid_q      <= 1'b1;
              no_carrier_q <= 1'b0;
              if (line_q) begin
                yuv_u_q <= yuv_u_d;
              end else begin
                yuv_v_q <= yuv_v_d;
              end
            end else begin
              count_q <= cnt_now;
              if (crossing) begin
                ncross_q <= ncross_q + 5'd1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign yuv_u      = yuv_u_q;
  assign yuv_v      = yuv_v_q;
  assign valid      = valid_q;
  assign no_carrier = no_carrier_q;

endmodule
